// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and hex decode for the seven-segment scan sequencer.
// Segment bit order within the segment byte is {dp,g,f,e,d,c,b,a}.
package seg_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int SEL_LSB = 8;
  localparam int SEG_LSB = 0;

  typedef enum logic [0:0] {
    S_WAIT    = 1'b0,
    S_PRESENT = 1'b1
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_sequencer_tick_prescaler.sv
// Free-running refresh divider: o_tick is a registered one-clock pulse every DIV clocks,
// first asserted DIV clocks after reset release.
module tick_prescaler #(
  parameter int DIV = 16000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Divider counter with wrap pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_W'(DIV - 1)) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CNT_W'(1);
      tick_r <= 1'b0;
    end
  end

  assign o_tick = tick_r;

endmodule

// File: rtl/seg_scan_sequencer.sv
// Multiplexes up to eight hex digits onto one 16-bit {select,segments} word stream
// handed to a 595 shift stage over valid/ready; each frame decodes from one snapshot.
module seg_scan_sequencer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16000
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic                    i_blank_lz,
  input  logic                    i_ready,
  output logic [15:0]             o_word,
  output logic                    o_valid,
  output logic                    o_frame_start,
  output logic                    o_overrun
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e             state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [4*NUM_DIGITS-1:0] snap_digits_r, snap_digits_s;
  logic [NUM_DIGITS-1:0]   snap_dp_r, snap_dp_s;
  logic                    snap_blz_r, snap_blz_s;
  logic [15:0]             word_r, word_s;
  logic                    valid_r, valid_s;
  logic                    fs_r, fs_s;
  logic                    over_r, over_s;

  logic                    tick_s;
  logic                    idx_zero_s;
  logic [4*NUM_DIGITS-1:0] cur_digits_s;
  logic [NUM_DIGITS-1:0]   cur_dp_s;
  logic                    cur_blz_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic                    zero_acc_s;
  logic [3:0]              nib_s;
  logic                    dp_bit_s;
  logic                    lz_bit_s;
  logic                    blank_s;
  logic [7:0]              sel_s;
  logic [7:0]              seg_s;
  logic [15:0]             built_word_s;

  tick_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (tick_s)
  );

  assign idx_zero_s = (idx_r == {IDX_W{1'b0}});

  // Word builder: digit 0 decodes from live inputs, which are captured into the snapshot on the same tick.
  always_comb begin
    if (idx_zero_s) begin
      cur_digits_s = i_digits;
      cur_dp_s     = i_dp_mask;
      cur_blz_s    = i_blank_lz;
    end else begin
      cur_digits_s = snap_digits_r;
      cur_dp_s     = snap_dp_r;
      cur_blz_s    = snap_blz_r;
    end

    zero_acc_s = 1'b1;
    lz_s       = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_acc_s = zero_acc_s & (cur_digits_s[4*k +: 4] == 4'h0);
      lz_s[k]    = zero_acc_s;
    end

    nib_s    = 4'h0;
    dp_bit_s = 1'b0;
    lz_bit_s = 1'b0;
    sel_s    = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_r == IDX_W'(k)) begin
        nib_s    = cur_digits_s[4*k +: 4];
        dp_bit_s = cur_dp_s[k];
        lz_bit_s = lz_s[k];
        sel_s[k] = 1'b1;
      end else begin
        sel_s[k] = 1'b0;
      end
    end

    blank_s = cur_blz_s && !idx_zero_s && lz_bit_s;

    seg_s = 8'h00;
    if (blank_s) begin
      seg_s[SEG_G:SEG_A] = 7'h00;
    end else begin
      seg_s[SEG_G:SEG_A] = hex_to_seg(nib_s);
    end
    seg_s[SEG_DP] = dp_bit_s;

    built_word_s                 = 16'h0000;
    built_word_s[SEL_LSB +: 8]   = sel_s;
    built_word_s[SEG_LSB +: 8]   = seg_s;
  end

  // Next-state logic: tick loads a word, acceptance retires it, a tick while presenting is dropped and flagged.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    word_s        = word_r;
    valid_s       = valid_r;
    fs_s          = 1'b0;
    over_s        = over_r;
    snap_digits_s = snap_digits_r;
    snap_dp_s     = snap_dp_r;
    snap_blz_s    = snap_blz_r;

    case (state_r)
      S_WAIT: begin
        if (tick_s) begin
          if (idx_zero_s) begin
            snap_digits_s = i_digits;
            snap_dp_s     = i_dp_mask;
            snap_blz_s    = i_blank_lz;
          end else begin
            snap_digits_s = snap_digits_r;
          end
          word_s  = built_word_s;
          valid_s = 1'b1;
          state_s = S_PRESENT;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_PRESENT: begin
        if (i_ready) begin
          valid_s = 1'b0;
          fs_s    = idx_zero_s;
          state_s = S_WAIT;
          if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
            idx_s = {IDX_W{1'b0}};
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = S_PRESENT;
        end
        if (tick_s) begin
          over_s = 1'b1;
        end else begin
          over_s = over_r;
        end
      end
      default: begin
        state_s = S_WAIT;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, snapshot and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= S_WAIT;
      idx_r         <= {IDX_W{1'b0}};
      word_r        <= 16'h0000;
      valid_r       <= 1'b0;
      fs_r          <= 1'b0;
      over_r        <= 1'b0;
      snap_digits_r <= {(4*NUM_DIGITS){1'b0}};
      snap_dp_r     <= {NUM_DIGITS{1'b0}};
      snap_blz_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      word_r        <= word_s;
      valid_r       <= valid_s;
      fs_r          <= fs_s;
      over_r        <= over_s;
      snap_digits_r <= snap_digits_s;
      snap_dp_r     <= snap_dp_s;
      snap_blz_r    <= snap_blz_s;
    end
  end

  assign o_word        = word_r;
  assign o_valid       = valid_r;
  assign o_frame_start = fs_r;
  assign o_overrun     = over_r;

endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Scoreboard bench for seg_scan_sequencer (NUM_DIGITS=4, REFRESH_DIV=4): a frame-level
// reference model queues expected words, a negedge monitor pops and compares them.
module tb_seg_scan_sequencer;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic [15:0] i_digits;
  logic [3:0]  i_dp_mask;
  logic        i_blank_lz;
  logic        i_ready;
  logic [15:0] o_word;
  logic        o_valid;
  logic        o_frame_start;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // reference model state
  int          m_edges;
  bit          m_busy;
  bit          m_over;
  bit          m_fs;
  int          m_idx;
  logic [15:0] m_sd;
  logic [3:0]  m_sp;
  bit          m_sb;
  logic [15:0] exp_q [$];

  seg_scan_sequencer #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_digits      (i_digits),
    .i_dp_mask     (i_dp_mask),
    .i_blank_lz    (i_blank_lz),
    .i_ready       (i_ready),
    .o_word        (o_word),
    .o_valid       (o_valid),
    .o_frame_start (o_frame_start),
    .o_overrun     (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_word(input int idx);
    logic [15:0] upper;
    logic [7:0]  seg;
    logic [7:0]  sel;
    upper = m_sd >> (4 * idx);
    seg   = seg_tab[upper[3:0]];
    if (m_sb && idx != 0 && upper == 16'h0000) seg = 8'h00;
    seg[7] = m_sp[idx];
    sel    = 8'(1 << idx);
    return {sel, seg};
  endfunction

  // Reference model: ticks every DIV clocks after release, one word in flight, frame-wide snapshot.
  initial begin
    bit tick;
    bit was_busy;
    m_edges = 0; m_busy = 0; m_over = 0; m_fs = 0; m_idx = 0;
    m_sd = 16'h0; m_sp = 4'h0; m_sb = 0;
    forever begin
      @(posedge i_clk or negedge i_reset_n);
      if (!i_reset_n) begin
        m_edges = 0; m_busy = 0; m_over = 0; m_fs = 0; m_idx = 0;
        m_sd = 16'h0; m_sp = 4'h0; m_sb = 0;
        exp_q.delete();
      end else begin
        tick     = (m_edges > 0) && (m_edges % DIV == 0);
        m_edges  = m_edges + 1;
        was_busy = m_busy;
        m_fs     = 0;
        if (was_busy && i_ready) begin
          m_fs   = (m_idx == 0);
          m_idx  = (m_idx + 1) % ND;
          m_busy = 0;
        end
        if (tick) begin
          if (was_busy) begin
            m_over = 1;
          end else begin
            if (m_idx == 0) begin
              m_sd = i_digits; m_sp = i_dp_mask; m_sb = i_blank_lz;
            end
            exp_q.push_back(model_word(m_idx));
            m_busy = 1;
          end
        end
      end
    end
  end

  // Monitor: pops an expected word whenever the DUT raises o_valid, and checks flags every cycle.
  initial begin
    bit          prev_v;
    logic [15:0] cur;
    prev_v = 0;
    cur    = 16'h0;
    forever begin
      @(negedge i_clk);
      if (!i_reset_n) begin
        prev_v = 0;
        check("reset_valid", o_valid, 1'b0);
      end else begin
        check("valid", o_valid, m_busy);
        check("overrun", o_overrun, m_over);
        check("frame_start", o_frame_start, m_fs);
        if (o_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", o_word, $time);
          end else begin
            cur = exp_q.pop_front();
            check("word", o_word, cur);
          end
        end else if (o_valid) begin
          check("word_hold", o_word, cur);
        end
        prev_v = o_valid;
      end
    end
  end

  task automatic wait_frames(input int n);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (o_frame_start) seen++;
    end
    check("frame_timeout", seen, n);
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (!o_valid && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    check("valid_timeout", o_valid, 1'b1);
  endtask

  task automatic check_first_valid();
    int cnt;
    cnt = 0;
    while (!o_valid && cnt < 20) begin
      @(posedge i_clk);
      #1;
      cnt++;
    end
    check("first_valid_latency", cnt, 5);
    check("first_word_sel", o_word[15:8], 8'h01);
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_digits   = 16'h1A2F;
    i_dp_mask  = 4'b0100;
    i_blank_lz = 1'b0;
    i_ready    = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_word", o_word, 16'h0000);
    check("rst_overrun", o_overrun, 1'b0);
    i_reset_n = 1'b1;
    check_first_valid();

    // full scan
    wait_frames(3);

    // leading-zero blank
    i_digits = 16'h0005; i_blank_lz = 1'b1; i_dp_mask = 4'b1000;
    wait_frames(2);

    // snapshot integrity
    i_digits = 16'h1234; i_blank_lz = 1'b0; i_dp_mask = 4'b0000;
    wait_frames(1);
    i_digits = 16'h9999;
    wait_frames(2);

    // decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      i_digits  = 16'(v);
      i_dp_mask = 4'(v & 1);
      wait_frames(1);
    end

    // randomized ready and inputs
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        i_digits   = 16'($urandom);
        i_dp_mask  = 4'($urandom);
        i_blank_lz = 1'($urandom);
        if ($urandom_range(0, 1) == 0) i_digits = i_digits & 16'h00FF;
      end
    end
    i_ready = 1'b1;
    wait_frames(1);

    // backpressure
    wait_valid();
    i_ready = 1'b0;
    repeat (10) @(negedge i_clk);
    check("bp_overrun", o_overrun, 1'b1);
    check("bp_still_valid", o_valid, 1'b1);
    i_ready = 1'b1;
    wait_frames(2);

    // asynchronous reset while presenting
    i_ready = 1'b0;
    @(negedge i_clk);
    wait_valid();
    #2;
    i_reset_n = 1'b0;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_word", o_word, 16'h0000);
    check("async_rst_overrun", o_overrun, 1'b0);
    check("async_rst_fs", o_frame_start, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_digits   = 16'hBEEF;
    i_dp_mask  = 4'b0001;
    i_blank_lz = 1'b0;
    i_ready    = 1'b1;
    i_reset_n  = 1'b1;
    check_first_valid();
    wait_frames(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
